tlb_refill_walker: RTL and testbench

Hardware refill engine that sits on the write side of the MMU's TLB. On a TLB miss from the pipeline, it fetches the even/odd PTE pair from a linear page table in memory and writes one complete TLB entry (EntryHi, EntryLo0, EntryLo1, PageMask) into a pseudo-random, non-wired TLB slot. It then reports completion or a page fault back to the requester.

---
 rtl/tlb_refill_walker_pkg.sv | 28 ++
 rtl/tlb_refill_walker_if.sv | 38 +++
 rtl/tlb_random_counter.sv | 38 +++
 rtl/tlb_refill_walker.sv | 158 +++++++++++++++
 tb/tb_tlb_refill_walker.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/tlb_refill_walker_pkg.sv
// Shared MMU definitions: MIPS TLB field positions and the refill walker state encoding.
package tlb_refill_walker_pkg;

    // Virtual address / EntryHi fields
    localparam int unsigned Vpn2Msb   = 31;
    localparam int unsigned Vpn2Lsb   = 13;
    localparam int unsigned Vpn2Width = Vpn2Msb - Vpn2Lsb + 1;
    localparam int unsigned AsidMsb   = 7;
    localparam int unsigned AsidLsb   = 0;

    // EntryLo flag bits
    localparam int unsigned EloGBit = 0;
    localparam int unsigned EloVBit = 1;
    localparam int unsigned EloDBit = 2;

    typedef enum logic [2:0] {
        StIdle,
        StRdEven,
        StRdOdd,
        StWrite,
        StDone
    } walk_state_e;

    function automatic logic pte_valid(input logic [31:0] pte);
        return pte[EloVBit];
    endfunction

endpackage

// File: rtl/tlb_refill_walker_if.sv
// Miss-request, page-table read and TLB write signals of the refill walker.
interface tlb_refill_walker_if #(
    parameter int unsigned ENTRY_ADDR_WIDTH = 3
);
    logic                        missReq;
    logic [31:0]                 missVAddr;
    logic [7:0]                  missAsid;
    logic [31:0]                 ptBase;
    logic [ENTRY_ADDR_WIDTH-1:0] wired;
    logic                        busy;
    logic                        done;
    logic                        fault;
    logic                        memReq;
    logic [31:0]                 memAddr;
    logic                        memAck;
    logic [31:0]                 memData;
    logic                        tlbWe;
    logic [31:0]                 tlbIndex;
    logic [31:0]                 tlbEntryHi;
    logic [31:0]                 tlbEntryLo0;
    logic [31:0]                 tlbEntryLo1;
    logic [31:0]                 tlbPageMask;

    // Walker side
    modport master (
        input  missReq, missVAddr, missAsid, ptBase, wired, memAck, memData,
        output busy, done, fault, memReq, memAddr,
        output tlbWe, tlbIndex, tlbEntryHi, tlbEntryLo0, tlbEntryLo1, tlbPageMask
    );

    // Requester / memory / TLB side
    modport slave (
        output missReq, missVAddr, missAsid, ptBase, wired, memAck, memData,
        input  busy, done, fault, memReq, memAddr,
        input  tlbWe, tlbIndex, tlbEntryHi, tlbEntryLo0, tlbEntryLo1, tlbPageMask
    );

endinterface

// File: rtl/tlb_random_counter.sv
// Wired-aware pseudo-random TLB replacement index: free-running down-counter that never
// lands in the wired slots [0, wired).
module tlb_random_counter #(
    parameter int unsigned ENTRY_ADDR_WIDTH = 3
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [ENTRY_ADDR_WIDTH-1:0] wired_i,
    output logic [ENTRY_ADDR_WIDTH-1:0] index_o
);
    localparam int unsigned EntryCount = 1 << ENTRY_ADDR_WIDTH;
    localparam logic [ENTRY_ADDR_WIDTH-1:0] LastIdx = ENTRY_ADDR_WIDTH'(EntryCount - 1);

    logic [ENTRY_ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [ENTRY_ADDR_WIDTH:0]   wired_ext;

    // Decrement, wrapping to the top slot once the counter reaches the wired boundary
    always_comb begin
        cnt_d = cnt_q - ENTRY_ADDR_WIDTH'(1);
        if (cnt_q <= wired_i) begin
            cnt_d = LastIdx;
        end
    end

    // Counter register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= LastIdx;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Guard kept for reuse with a wider wired field: fully wired TLB uses the top slot
    assign wired_ext = {1'b0, wired_i};
    assign index_o   = (wired_ext >= (ENTRY_ADDR_WIDTH + 1)'(EntryCount)) ? LastIdx : cnt_q;

endmodule

// File: rtl/tlb_refill_walker.sv
// TLB refill walker: reads the even/odd PTE pair for a missing VPN2 from a linear page
// table and writes one TLB entry into a non-wired slot, or reports a fault.
module tlb_refill_walker
    import tlb_refill_walker_pkg::*;
#(
    parameter int unsigned ENTRY_ADDR_WIDTH = 3,
    parameter logic [31:0] PAGE_MASK        = 32'h0
) (
    input logic                 clk,
    input logic                 res,
    tlb_refill_walker_if.master bus
);
    walk_state_e                 state_q, state_d;
    logic [Vpn2Width-1:0]        vpn2_q, vpn2_d;
    logic [7:0]                  asid_q, asid_d;
    logic [31:0]                 pte0_q, pte0_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        fault_q, fault_d;
    logic                        mem_req_q, mem_req_d;
    logic [31:0]                 mem_addr_q, mem_addr_d;
    logic                        tlb_we_q, tlb_we_d;
    logic [ENTRY_ADDR_WIDTH-1:0] tlb_index_q, tlb_index_d;
    logic [31:0]                 entry_hi_q, entry_hi_d;
    logic [31:0]                 entry_lo0_q, entry_lo0_d;
    logic [31:0]                 entry_lo1_q, entry_lo1_d;
    logic [31:0]                 page_mask_q, page_mask_d;
    logic [ENTRY_ADDR_WIDTH-1:0] rand_index;
    logic                        unused_vaddr_lo;

    tlb_random_counter #(
        .ENTRY_ADDR_WIDTH(ENTRY_ADDR_WIDTH)
    ) u_random_counter (
        .clk_i  (clk),
        .rst_ni (res),
        .wired_i(bus.wired),
        .index_o(rand_index)
    );

    // Walk sequencing; every output is computed here and registered below
    always_comb begin
        state_d     = state_q;
        vpn2_d      = vpn2_q;
        asid_d      = asid_q;
        pte0_d      = pte0_q;
        done_d      = 1'b0;
        fault_d     = 1'b0;
        tlb_we_d    = 1'b0;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        tlb_index_d = tlb_index_q;
        entry_hi_d  = entry_hi_q;
        entry_lo0_d = entry_lo0_q;
        entry_lo1_d = entry_lo1_q;
        page_mask_d = page_mask_q;
        case (state_q)
            StIdle: begin
                if (bus.missReq) begin
                    vpn2_d     = bus.missVAddr[Vpn2Msb:Vpn2Lsb];
                    asid_d     = bus.missAsid[AsidMsb:AsidLsb];
                    // Each PTE pair is 8 bytes; the add wraps at 2^32
                    mem_addr_d = bus.ptBase + 32'({bus.missVAddr[Vpn2Msb:Vpn2Lsb], 3'b000});
                    mem_req_d  = 1'b1;
                    state_d    = StRdEven;
                end
            end
            StRdEven: begin
                if (bus.memAck) begin
                    pte0_d     = bus.memData;
                    mem_addr_d = mem_addr_q + 32'd4;
                    state_d    = StRdOdd;
                end
            end
            StRdOdd: begin
                if (bus.memAck) begin
                    mem_req_d = 1'b0;
                    if (!pte_valid(pte0_q) && !pte_valid(bus.memData)) begin
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                        state_d = StDone;
                    end else begin
                        tlb_we_d    = 1'b1;
                        tlb_index_d = rand_index;
                        entry_hi_d  = {vpn2_q, 5'b0, asid_q};
                        entry_lo0_d = pte0_q;
                        entry_lo1_d = bus.memData;
                        page_mask_d = PAGE_MASK;
                        state_d     = StWrite;
                    end
                end
            end
            StWrite: begin
                done_d  = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    // State and output registers; reset abandons any outstanding read
    always_ff @(posedge clk) begin
        if (!res) begin
            state_q     <= StIdle;
            vpn2_q      <= '0;
            asid_q      <= '0;
            pte0_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            tlb_we_q    <= 1'b0;
            tlb_index_q <= '0;
            entry_hi_q  <= '0;
            entry_lo0_q <= '0;
            entry_lo1_q <= '0;
            page_mask_q <= '0;
        end else begin
            state_q     <= state_d;
            vpn2_q      <= vpn2_d;
            asid_q      <= asid_d;
            pte0_q      <= pte0_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            tlb_we_q    <= tlb_we_d;
            tlb_index_q <= tlb_index_d;
            entry_hi_q  <= entry_hi_d;
            entry_lo0_q <= entry_lo0_d;
            entry_lo1_q <= entry_lo1_d;
            page_mask_q <= page_mask_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.fault       = fault_q;
    assign bus.memReq      = mem_req_q;
    assign bus.memAddr     = mem_addr_q;
    assign bus.tlbWe       = tlb_we_q;
    assign bus.tlbIndex    = 32'(tlb_index_q);
    assign bus.tlbEntryHi  = entry_hi_q;
    assign bus.tlbEntryLo0 = entry_lo0_q;
    assign bus.tlbEntryLo1 = entry_lo1_q;
    assign bus.tlbPageMask = page_mask_q;

    // Page offset bits of the faulting address play no part in the refill
    assign unused_vaddr_lo = ^bus.missVAddr[Vpn2Lsb-1:0];

endmodule

// File: tb/tb_tlb_refill_walker.sv
// Bench for tlb_refill_walker: per-walk timeline model plus a replacement-counter model,
// compared against the DUT every cycle, with literal expectations for directed walks.
module tb_tlb_refill_walker;
    localparam int          AW = 3;
    localparam int          N  = 1 << AW;
    localparam logic [31:0] PM = 32'h0;

    logic clk = 1'b0;
    logic res = 1'b0;
    always #5 clk = ~clk;

    tlb_refill_walker_if #(.ENTRY_ADDR_WIDTH(AW)) bus ();

    tlb_refill_walker #(
        .ENTRY_ADDR_WIDTH(AW),
        .PAGE_MASK       (PM)
    ) dut (
        .clk(clk),
        .res(res),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Cycle index and replacement counter reference
    int cyc     = 0;
    int ref_cnt = N - 1;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        if (!res) ref_cnt <= N - 1;
        else if (ref_cnt <= int'(bus.wired)) ref_cnt <= N - 1;
        else ref_cnt <= ref_cnt - 1;
    end

    // Current walk descriptor (cycle 0 = the cycle missReq is driven)
    bit          w_valid = 1'b0;
    int          w_c0, w_d0, w_d1;
    logic [31:0] w_va, w_base, w_p0, w_p1;
    logic [7:0]  w_asid;

    // Observations from the most recent run_walk
    logic [31:0] obs_even, obs_odd, obs_hi, obs_idx;
    int          obs_done_t;
    bit          obs_fault, obs_we;

    // Compare process: expected outputs from the walk timeline and the counter model
    initial begin
        int t, e, oe, wt, dt, prev_cnt;
        bit f, x_req, x_we, x_done, x_busy;
        logic [31:0] even;
        prev_cnt = N - 1;
        forever begin
            @(negedge clk);
            x_req = 0; x_we = 0; x_done = 0; x_busy = 0; f = 0; even = '0; e = 0;
            if (w_valid) begin
                t    = cyc - w_c0;
                e    = 1 + w_d0;
                oe   = 2 + w_d0 + w_d1;
                wt   = oe + 1;
                f    = !w_p0[1] && !w_p1[1];
                dt   = f ? wt : wt + 1;
                even = w_base + ((w_va >> 13) << 3);
                x_req  = (t >= 1) && (t <= oe);
                x_we   = !f && (t == wt);
                x_done = (t == dt);
                x_busy = (t >= 1) && (t <= dt);
                if (x_req) check("memAddr", bus.memAddr, (t <= e) ? even : even + 32'd4);
            end
            check("busy", 32'(bus.busy), 32'(x_busy));
            check("memReq", 32'(bus.memReq), 32'(x_req));
            check("tlbWe", 32'(bus.tlbWe), 32'(x_we));
            check("done", 32'(bus.done), 32'(x_done));
            check("fault", 32'(bus.fault), 32'(x_done && f));
            if (x_we) begin
                check("tlbEntryHi", bus.tlbEntryHi, {w_va[31:13], 5'b0, w_asid});
                check("tlbEntryLo0", bus.tlbEntryLo0, w_p0);
                check("tlbEntryLo1", bus.tlbEntryLo1, w_p1);
                check("tlbPageMask", bus.tlbPageMask, PM);
                check("tlbIndex", bus.tlbIndex, 32'(prev_cnt));
            end
            prev_cnt = ref_cnt;
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.memAck  = 1'($urandom_range(0, 1));
            bus.memData = $urandom;
            @(posedge clk); #1;
        end
        bus.memAck = 1'b0;
    endtask

    // Issue one miss and serve both reads after d0/d1 wait cycles; returns in an idle cycle
    task automatic run_walk(input logic [31:0] va, input logic [7:0] asid,
                            input logic [31:0] base, input logic [31:0] p0,
                            input logic [31:0] p1, input int d0, input int d1,
                            input bit extra_req);
        int e, oe, dn;
        bit f;
        f  = !p0[1] && !p1[1];
        e  = 1 + d0;
        oe = 2 + d0 + d1;
        dn = f ? oe + 1 : oe + 2;
        w_va = va; w_asid = asid; w_base = base; w_p0 = p0; w_p1 = p1;
        w_d0 = d0; w_d1 = d1; w_c0 = cyc; w_valid = 1'b1;
        obs_done_t = -1; obs_we = 0; obs_fault = 0;
        obs_even = 'x; obs_odd = 'x; obs_hi = 'x; obs_idx = 'x;
        bus.missReq = 1'b1; bus.missVAddr = va; bus.missAsid = asid; bus.ptBase = base;
        bus.memAck = 1'b0;
        for (int t = 1; t <= dn + 1; t++) begin
            @(posedge clk); #1;
            bus.missReq = extra_req && (t == 2);
            if (bus.missReq) begin
                bus.missVAddr = $urandom; bus.ptBase = $urandom; bus.missAsid = 8'($urandom);
            end
            if (t == 1) obs_even = bus.memAddr;
            if (t == e + 1) obs_odd = bus.memAddr;
            if (bus.tlbWe) begin
                obs_we = 1; obs_hi = bus.tlbEntryHi; obs_idx = bus.tlbIndex;
            end
            if (bus.done && obs_done_t < 0) begin
                obs_done_t = t; obs_fault = bus.fault;
            end
            if (t == e) begin
                bus.memAck = 1'b1; bus.memData = p0;
            end else if (t == oe) begin
                bus.memAck = 1'b1; bus.memData = p1;
            end else begin
                bus.memAck  = (t > oe) ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.memData = $urandom;
            end
        end
        bus.memAck = 1'b0;
    endtask

    initial begin
        bit in_range;
        bus.missReq = 0; bus.missVAddr = 0; bus.missAsid = 0; bus.ptBase = 0;
        bus.wired = '0; bus.memAck = 0; bus.memData = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_memAddr", bus.memAddr, 32'h0);
        check("rst_tlbIndex", bus.tlbIndex, 32'h0);
        check("rst_entryHi", bus.tlbEntryHi, 32'h0);
        res = 1'b1;
        idle(2);

        // Basic refill
        run_walk(32'h0040_3123, 8'h05, 32'h0010_0000, 32'h0000_1006, 32'h0000_2002, 0, 0, 0);
        check("basic_even", obs_even, 32'h0010_1008);
        check("basic_odd", obs_odd, 32'h0010_100C);
        check("basic_hi", obs_hi, 32'h0040_2005);
        check("basic_done_t", 32'(obs_done_t), 32'd4);
        check("basic_fault", 32'(obs_fault), 32'd0);

        // Both PTEs invalid
        run_walk(32'h1234_5678, 8'h11, 32'h0020_0000, 32'h0, 32'h4, 0, 0, 0);
        check("fault_we", 32'(obs_we), 32'd0);
        check("fault_done_t", 32'(obs_done_t), 32'd3);
        check("fault_flag", 32'(obs_fault), 32'd1);

        // Three wait cycles on each read
        run_walk(32'h8000_6000, 8'hA0, 32'h0030_0000, 32'h0000_0002, 32'h0, 3, 3, 0);
        check("wait_done_t", 32'(obs_done_t), 32'd10);

        // Table base wrap-around
        run_walk(32'h0000_2000, 8'h01, 32'hFFFF_FFF8, 32'h2, 32'h2, 0, 0, 0);
        check("wrap_even", obs_even, 32'h0000_0000);
        check("wrap_odd", obs_odd, 32'h0000_0004);

        // Back-to-back refills with two wired slots
        bus.wired = 3'd2;
        for (int i = 0; i < 10; i++) begin
            run_walk($urandom, 8'($urandom), $urandom, 32'h2, $urandom, 0, 0, 0);
            in_range = (obs_idx >= 32'd2) && (obs_idx <= 32'd7);
            check("wired2_range", 32'(in_range), 32'd1);
        end

        // Everything but the top slot wired
        bus.wired = 3'd7;
        run_walk(32'h0ABC_0000, 8'h33, 32'h0, 32'h6, 32'h0, 1, 0, 0);
        check("wired7_idx", obs_idx, 32'd7);
        bus.wired = 3'd0;

        // Reset during the odd read, then a late ack
        w_va = 32'h0055_E000; w_asid = 8'h44; w_base = 32'h0100_0000;
        w_p0 = 32'h2; w_p1 = 32'h2; w_d0 = 0; w_d1 = 3; w_c0 = cyc; w_valid = 1'b1;
        bus.missReq = 1; bus.missVAddr = w_va; bus.missAsid = w_asid; bus.ptBase = w_base;
        @(posedge clk); #1;
        bus.missReq = 0; bus.memAck = 1; bus.memData = w_p0;
        @(posedge clk); #1;
        bus.memAck = 0; res = 1'b0;
        @(posedge clk); #1;
        res = 1'b1; w_valid = 1'b0; bus.memAck = 1; bus.memData = 32'hDEAD_BEEF;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_memAddr", bus.memAddr, 32'h0);
        check("midrst_lo0", bus.tlbEntryLo0, 32'h0);
        @(posedge clk); #1;
        bus.memAck = 0;
        check("late_ack_memReq", 32'(bus.memReq), 32'd0);
        idle(3);

        // Second miss while busy must be ignored
        run_walk(32'h0077_8000, 8'h09, 32'h0040_0000, 32'h0000_3002, 32'h0000_4006, 1, 1, 1);
        check("extra_hi", obs_hi, 32'h0077_8009);
        idle(4);

        // Randomised walks
        for (int i = 0; i < 40; i++) begin
            bus.wired = 3'($urandom_range(0, 7));
            run_walk($urandom, 8'($urandom), $urandom, $urandom & 32'hFFFF_FFF6 | 32'($urandom_range(0, 1) << 1),
                     $urandom, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            idle($urandom_range(0, 2));
        end

        @(posedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
